// File: rtl/mdio_master_22_45_engine.sv
// MDIO Clause 22/45 management initiator: serialises one frame per accepted
// request onto MDIO/MDC and shifts read data back in on rising MDC.
module mdio_master_22_45_engine #(
    parameter int CLK_DIV = 5
) (
    input  logic        clk_25m,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_st,
    input  logic [1:0]  req_op,
    input  logic [4:0]  req_phyad,
    input  logic [4:0]  req_regad,
    input  logic [15:0] req_wdata,
    input  logic        preamble_en,
    input  logic        opendrain_mode,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        mdc,
    output logic        mdio_out,
    output logic        mdio_oe,
    input  logic        mdio_in
);
    typedef enum logic [1:0] {IDLE, PRE, FRAME, DONE} state_t;

    localparam logic [5:0] DIV_LAST = 6'(CLK_DIV - 1);

    state_t      state;
    logic [5:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic [31:0] frame_sh;
    logic [15:0] rd_sh;
    logic        is_read;
    logic        oe_r;
    logic        mdio_in_p0;
    logic        mdio_in_p1;
    logic        accept;
    logic        next_driven;

    assign req_ready   = (state == IDLE);
    assign accept      = req_valid && req_ready;
    assign mdio_oe     = opendrain_mode ? (oe_r & ~mdio_out) : oe_r;
    // A read releases the line from the turnaround (bit 14) onwards.
    assign next_driven = !is_read || (bit_cnt < 5'd13);

    // Two-flop synchroniser for the asynchronous PHY data line.
    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            mdio_in_p0 <= 1'b1;
            mdio_in_p1 <= 1'b1;
        end else begin
            mdio_in_p0 <= mdio_in;
            mdio_in_p1 <= mdio_in_p0;
        end
    end

    always_ff @(posedge clk_25m or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            frame_sh   <= '0;
            rd_sh      <= '0;
            is_read    <= 1'b0;
            oe_r       <= 1'b0;
            mdc        <= 1'b0;
            mdio_out   <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    mdc     <= 1'b0;
                    if (accept) begin
                        frame_sh <= {req_st, req_op, req_phyad, req_regad, 2'b10, req_wdata};
                        is_read  <= req_op[1];
                        oe_r     <= 1'b1;
                        if (preamble_en) begin
                            state    <= PRE;
                            mdio_out <= 1'b1;
                        end else begin
                            state    <= FRAME;
                            mdio_out <= req_st[1];
                        end
                    end
                end
                PRE, FRAME: begin
                    if (div_cnt != DIV_LAST) begin
                        div_cnt <= div_cnt + 6'd1;
                    end else begin
                        div_cnt <= '0;
                        mdc     <= ~mdc;
                        if (!mdc) begin
                            // Rising MDC: only the last 16 shifts survive to the response.
                            if (state == FRAME) rd_sh <= {rd_sh[14:0], mdio_in_p1};
                        end else if (bit_cnt != 5'd31) begin
                            bit_cnt <= bit_cnt + 5'd1;
                            if (state == FRAME) begin
                                frame_sh <= {frame_sh[30:0], 1'b0};
                                oe_r     <= next_driven;
                                mdio_out <= next_driven ? frame_sh[30] : 1'b1;
                            end
                        end else if (state == PRE) begin
                            state    <= FRAME;
                            bit_cnt  <= '0;
                            mdio_out <= frame_sh[31];
                        end else begin
                            state      <= DONE;
                            bit_cnt    <= '0;
                            oe_r       <= 1'b0;
                            mdio_out   <= 1'b1;
                            resp_valid <= 1'b1;
                            resp_rdata <= is_read ? rd_sh : 16'h0000;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdio_master_22_45_engine.sv
// Directed and randomised bench for mdio_master_22_45_engine with a timing
// reference model computed from bit index and phase arithmetic.
module tb_mdio_master_22_45_engine;
    localparam int D = 5;

    logic        clk_25m = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_st = 2'b01;
    logic [1:0]  req_op = 2'b01;
    logic [4:0]  req_phyad = '0;
    logic [4:0]  req_regad = '0;
    logic [15:0] req_wdata = '0;
    logic        preamble_en = 1'b0;
    logic        opendrain_mode = 1'b0;
    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic        mdc;
    logic        mdio_out;
    logic        mdio_oe;
    logic        mdio_in = 1'b1;

    int errors = 0;
    int checks = 0;
    time last_done_t = 0;
    logic [15:0] last_rdata = 16'h0000;

    mdio_master_22_45_engine #(.CLK_DIV(D)) dut (
        .clk_25m(clk_25m), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_st(req_st), .req_op(req_op), .req_phyad(req_phyad), .req_regad(req_regad),
        .req_wdata(req_wdata), .preamble_en(preamble_en), .opendrain_mode(opendrain_mode),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .mdc(mdc), .mdio_out(mdio_out),
        .mdio_oe(mdio_oe), .mdio_in(mdio_in)
    );

    always #20 clk_25m = ~clk_25m;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic run_txn(input logic [1:0] st, input logic [1:0] op, input logic [4:0] pa,
                           input logic [4:0] ra, input logic [15:0] wd, input logic pre,
                           input logic od, input logic [15:0] slave_rd, input bit keep_valid,
                           input int pulse_k, input int rst_k, input bit check_gap,
                           input string nm);
        logic [31:0] fw;
        logic        rd, ed, eo;
        int          p, n, w, b, ph, j;
        rd = op[1];
        fw = {st, op, pa, ra, 2'b10, wd};
        p  = pre ? 32 : 0;
        n  = (p + 32) * 2 * D;
        w  = 0;
        while (!req_ready && w < 200) begin
            @(negedge clk_25m);
            w++;
        end
        chk({nm, "_ready"}, 16'(req_ready), 16'd1);
        req_st = st; req_op = op; req_phyad = pa; req_regad = ra; req_wdata = wd;
        preamble_en = pre; opendrain_mode = od; mdio_in = 1'b1; req_valid = 1'b1;
        @(posedge clk_25m);
        if (check_gap) chk({nm, "_gap_ok"}, 16'(($time - last_done_t) / 40 >= 2), 16'd1);
        for (int k = 0; k <= n + 1; k++) begin
            @(negedge clk_25m);
            if (k == 0 && !keep_valid) req_valid = 1'b0;
            if (k == 0) begin
                // Scramble the request fields: latched copies must be used.
                req_st = ~st; req_op = ~op; req_phyad = ~pa; req_regad = ~ra; req_wdata = ~wd;
                preamble_en = ~pre;
            end
            if (k == pulse_k) req_valid = 1'b1;
            if (k == pulse_k + 1 && !keep_valid) req_valid = 1'b0;
            j = k / (2 * D) - p;
            mdio_in = (rd && j >= 16 && j <= 31) ? slave_rd[31 - j] : 1'b1;
            if (k == rst_k) begin
                rst_n = 1'b0;
                #1;
                chk({nm, "_rst_mdc"}, 16'(mdc), 16'd0);
                chk({nm, "_rst_mdio_out"}, 16'(mdio_out), 16'd1);
                chk({nm, "_rst_oe"}, 16'(mdio_oe), 16'd0);
                chk({nm, "_rst_ready"}, 16'(req_ready), 16'd1);
                chk({nm, "_rst_rdata"}, resp_rdata, 16'h0000);
                last_rdata = 16'h0000;
                for (int r = 0; r < 3; r++) begin
                    @(negedge clk_25m);
                    chk({nm, "_rst_no_resp"}, 16'(resp_valid), 16'd0);
                end
                rst_n = 1'b1;
                req_valid = 1'b0;
                for (int r = 0; r < 2 * n; r++) begin
                    @(negedge clk_25m);
                    if (resp_valid) break;
                end
                chk({nm, "_no_resp_after_rst"}, 16'(resp_valid), 16'd0);
                return;
            end
            if (k < n) begin
                b  = k / (2 * D);
                ph = k % (2 * D);
                if (b < p) begin
                    ed = 1'b1; eo = 1'b1;
                end else begin
                    j  = b - p;
                    ed = !rd || j < 14;
                    eo = fw[31 - j];
                end
                chk({nm, "_mdc"}, 16'(mdc), 16'(ph >= D));
                chk({nm, "_busy_resp"}, 16'(resp_valid), 16'd0);
                chk({nm, "_busy_ready"}, 16'(req_ready), 16'd0);
                if (ed) chk({nm, "_mdio_out"}, 16'(mdio_out), 16'(eo));
                chk({nm, "_mdio_oe"}, 16'(mdio_oe), 16'(ed && (!od || !eo)));
            end else if (k == n) begin
                last_done_t = $time - 20;
                last_rdata  = rd ? slave_rd : 16'h0000;
                chk({nm, "_resp_valid"}, 16'(resp_valid), 16'd1);
                chk({nm, "_resp_rdata"}, resp_rdata, last_rdata);
                chk({nm, "_done_mdc"}, 16'(mdc), 16'd0);
                chk({nm, "_done_oe"}, 16'(mdio_oe), 16'd0);
                chk({nm, "_done_ready"}, 16'(req_ready), 16'd0);
            end else begin
                chk({nm, "_idle_ready"}, 16'(req_ready), 16'd1);
                chk({nm, "_idle_resp"}, 16'(resp_valid), 16'd0);
                chk({nm, "_idle_mdc"}, 16'(mdc), 16'd0);
                chk({nm, "_idle_mdio_out"}, 16'(mdio_out), 16'd1);
                chk({nm, "_idle_oe"}, 16'(mdio_oe), 16'd0);
                chk({nm, "_rdata_held"}, resp_rdata, last_rdata);
            end
        end
    endtask

    initial begin
        logic [1:0]  r_st, r_op;
        logic [15:0] r_wd, r_rd;
        logic [4:0]  r_pa, r_ra;
        logic        r_pre, r_od;

        repeat (3) @(negedge clk_25m);
        chk("reset_mdc", 16'(mdc), 16'd0);
        chk("reset_mdio_out", 16'(mdio_out), 16'd1);
        chk("reset_oe", 16'(mdio_oe), 16'd0);
        chk("reset_ready", 16'(req_ready), 16'd1);
        chk("reset_resp_valid", 16'(resp_valid), 16'd0);
        chk("reset_rdata", resp_rdata, 16'h0000);
        rst_n = 1'b1;
        @(negedge clk_25m);

        run_txn(2'b01, 2'b01, 5'h03, 5'h1F, 16'hBEEF, 1'b1, 1'b0, 16'h0000, 0, -1, -1, 0, "c22_wr");
        run_txn(2'b01, 2'b10, 5'h03, 5'h02, 16'h0000, 1'b1, 1'b0, 16'hA5C3, 0, -1, -1, 0, "c22_rd");
        run_txn(2'b00, 2'b00, 5'h01, 5'h07, 16'h1234, 1'b0, 1'b0, 16'h0000, 0, -1, -1, 0, "c45_addr");
        run_txn(2'b01, 2'b01, 5'h0A, 5'h11, 16'h00FF, 1'b1, 1'b1, 16'h0000, 0, -1, -1, 0, "od_wr");
        run_txn(2'b01, 2'b01, 5'h12, 5'h05, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 0, 300, -1, 0, "busy_pulse");
        run_txn(2'b01, 2'b01, 5'h04, 5'h09, 16'hC0DE, 1'b0, 1'b0, 16'h0000, 1, -1, -1, 0, "b2b_a");
        run_txn(2'b01, 2'b11, 5'h04, 5'h0A, 16'h0000, 1'b0, 1'b0, 16'h3C96, 0, -1, -1, 1, "b2b_b");
        run_txn(2'b01, 2'b10, 5'h07, 5'h01, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 0, -1,
                (32 + 20) * 2 * D + 2, 0, "rst_mid");
        run_txn(2'b01, 2'b10, 5'h07, 5'h01, 16'h0000, 1'b1, 1'b0, 16'h1E87, 0, -1, -1, 0, "after_rst");

        for (int i = 0; i < 4; i++) begin
            r_st  = ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00;
            r_op  = 2'($urandom_range(0, 3));
            r_pa  = 5'($urandom);
            r_ra  = 5'($urandom);
            r_wd  = 16'($urandom);
            r_rd  = 16'($urandom);
            r_pre = 1'($urandom_range(0, 1));
            r_od  = 1'($urandom_range(0, 1));
            run_txn(r_st, r_op, r_pa, r_ra, r_wd, r_pre, r_od, r_rd, 0, -1, -1, 0, "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
